// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU execute-stage controller:
//     - datapath widths
//     - 6-bit ALU opcode constants (same encoding as the ALU instr port)
//     - PSW bit indices and update masks
//     - controller FSM state enumeration
//     - small opcode classification helpers
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DW  = 16;   // data / PSW width
    localparam int OPW = 6;    // opcode width
    localparam int RW  = 3;    // register index width

    // Opcodes: bit 0 selects byte (.b) variant; 11xxxx is the shift/rotate group.
    localparam logic [OPW-1:0] OP_MOV    = 6'b000000;
    localparam logic [OPW-1:0] OP_MOV_B  = 6'b000001;
    localparam logic [OPW-1:0] OP_ADD    = 6'b000010;
    localparam logic [OPW-1:0] OP_ADD_B  = 6'b000011;
    localparam logic [OPW-1:0] OP_ADDC   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDC_B = 6'b000101;
    localparam logic [OPW-1:0] OP_SUB    = 6'b000110;
    localparam logic [OPW-1:0] OP_SUB_B  = 6'b000111;
    localparam logic [OPW-1:0] OP_SUBC   = 6'b001000;
    localparam logic [OPW-1:0] OP_SUBC_B = 6'b001001;
    localparam logic [OPW-1:0] OP_CMP    = 6'b001010;
    localparam logic [OPW-1:0] OP_CMP_B  = 6'b001011;
    localparam logic [OPW-1:0] OP_DADD   = 6'b001100;
    localparam logic [OPW-1:0] OP_DADD_B = 6'b001101;
    localparam logic [OPW-1:0] OP_AND    = 6'b001110;
    localparam logic [OPW-1:0] OP_AND_B  = 6'b001111;
    localparam logic [OPW-1:0] OP_BIS    = 6'b010000;
    localparam logic [OPW-1:0] OP_BIS_B  = 6'b010001;
    localparam logic [OPW-1:0] OP_XOR    = 6'b010010;
    localparam logic [OPW-1:0] OP_XOR_B  = 6'b010011;
    localparam logic [OPW-1:0] OP_RRC    = 6'b110000;
    localparam logic [OPW-1:0] OP_RRC_B  = 6'b110001;
    localparam logic [OPW-1:0] OP_RRA    = 6'b110010;
    localparam logic [OPW-1:0] OP_RRA_B  = 6'b110011;

    // PSW bit positions
    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_S = 3;
    localparam int PSW_V = 4;

    // Flags copied from the ALU on a full update (V,N,Z,C) and on a carry-only update.
    localparam logic [DW-1:0] PSW_FLAG_MASK  = (DW'(1) << PSW_V) | (DW'(1) << PSW_N) |
                                               (DW'(1) << PSW_Z) | (DW'(1) << PSW_C);
    localparam logic [DW-1:0] PSW_CARRY_MASK = DW'(1) << PSW_C;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_DST = 3'd1,
        S_RD_SRC = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5
    } state_e;

    // Operation captured when start is accepted.
    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic           upd_psw;
        logic [RW-1:0]  dst;
        logic [RW-1:0]  src;
        logic           rc;
        logic [DW-1:0]  cval;
    } req_t;

    // Decimal add and rotate-through-carry always refresh C even without upd_psw.
    function automatic logic is_carry_only(input logic [OPW-1:0] op);
        return (op == OP_DADD) || (op == OP_DADD_B) || (op == OP_RRC) || (op == OP_RRC_B);
    endfunction

    // Single-operand shift/rotate group: second operand is forced to zero.
    function automatic logic is_shift(input logic [OPW-1:0] op);
        return op[OPW-1 -: 2] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//   Sequences one ALU operation through a fixed 6-state pipeline:
//   IDLE -> RD_DST -> RD_SRC -> EXEC -> WAIT -> WB -> IDLE.
//   Reads both operands from a combinational register file, pulses the ALU
//   execute strobe, captures result/flags, then writes back and updates PSW.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 accept one operation (IDLE only)
//   opcode, upd_psw       ALU operation and PSW-update option
//   dst_reg, src_reg      destination/first operand and source register index
//   rc, const_val         select immediate second operand
//   rf_raddr / rf_rdata   register-file read port (combinational data)
//   rf_we/waddr/wdata     register-file write port (one-cycle strobe)
//   op1, op2              ALU operands
//   alu_instr, alu_opt    ALU opcode and PSW-update option
//   alu_E                 ALU execute strobe
//   alu_result, alu_psw   ALU outputs
//   psw                   architectural PSW (also ALU PSW input)
//   busy, done            activity flag and completion pulse
// -----------------------------------------------------------------------------
module alu_ctrl
    import alu_pkg::*;
#(
    parameter logic [DW-1:0]      PSW_RST = 16'h0000,
    parameter logic [2*OPW-1:0]   CMP_OPS = {6'b001010, 6'b001011}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            upd_psw,
    input  logic [RW-1:0]   dst_reg,
    input  logic [RW-1:0]   src_reg,
    input  logic            rc,
    input  logic [DW-1:0]   const_val,
    output logic [RW-1:0]   rf_raddr,
    input  logic [DW-1:0]   rf_rdata,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [DW-1:0]   op1,
    output logic [DW-1:0]   op2,
    output logic [OPW-1:0]  alu_instr,
    output logic            alu_opt,
    output logic            alu_E,
    input  logic [DW-1:0]   alu_result,
    input  logic [DW-1:0]   alu_psw,
    output logic [DW-1:0]   psw,
    output logic            busy,
    output logic            done
);

    state_e         state_q, state_d;
    req_t           req_q;
    logic [DW-1:0]  op1_q, op2_q;
    logic [DW-1:0]  res_q, apsw_q;
    logic [DW-1:0]  psw_q, psw_d;
    logic [DW-1:0]  psw_mask;
    logic           is_cmp;

    // Compares update flags only; they never write the register file.
    assign is_cmp = (req_q.opcode == CMP_OPS[2*OPW-1 -: OPW]) ||
                    (req_q.opcode == CMP_OPS[OPW-1:0]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_RD_DST;
            S_RD_DST: state_d = S_RD_SRC;
            S_RD_SRC: state_d = S_EXEC;
            S_EXEC:   state_d = S_WAIT;
            S_WAIT:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy     = 1'b1;
        done     = 1'b0;
        rf_we    = 1'b0;
        alu_E    = 1'b0;
        rf_raddr = '0;
        unique case (state_q)
            S_IDLE:   busy     = 1'b0;
            S_RD_DST: rf_raddr = req_q.dst;
            S_RD_SRC: rf_raddr = req_q.src;
            S_EXEC:   alu_E    = 1'b1;
            S_WAIT:   ;
            S_WB: begin
                done  = 1'b1;
                rf_we = !is_cmp;
            end
            default:  busy     = 1'b0;
        endcase
    end

    // Full flag update wins; otherwise carry-only ops refresh C alone.
    always_comb begin
        psw_mask = '0;
        if (req_q.upd_psw)                   psw_mask = PSW_FLAG_MASK;
        else if (is_carry_only(req_q.opcode)) psw_mask = PSW_CARRY_MASK;
        psw_d = (psw_q & ~psw_mask) | (apsw_q & psw_mask);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            op1_q  <= '0;
            op2_q  <= '0;
            res_q  <= '0;
            apsw_q <= '0;
            psw_q  <= PSW_RST;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    req_q.opcode  <= opcode;
                    req_q.upd_psw <= upd_psw;
                    req_q.dst     <= dst_reg;
                    req_q.src     <= src_reg;
                    req_q.rc      <= rc;
                    req_q.cval    <= const_val;
                end
                S_RD_DST: op1_q <= rf_rdata;
                S_RD_SRC: begin
                    if (is_shift(req_q.opcode)) op2_q <= '0;
                    else if (req_q.rc)          op2_q <= req_q.cval;
                    else                        op2_q <= rf_rdata;
                end
                S_EXEC: ;
                S_WAIT: begin
                    res_q  <= alu_result;
                    apsw_q <= alu_psw;
                end
                S_WB:    psw_q <= psw_d;
                default: ;
            endcase
        end
    end

    assign op1       = op1_q;
    assign op2       = op2_q;
    assign alu_instr = req_q.opcode;
    assign alu_opt   = req_q.upd_psw;
    assign rf_waddr  = req_q.dst;
    assign rf_wdata  = res_q;
    assign psw       = psw_q;

endmodule
